// File: rtl/weight_loader_m_axi_rd_arbiter_if.sv
// rtl/weight_loader_m_axi_rd_arbiter_if.sv - requester and m_axi read-channel bundle for the read arbiter
interface weight_loader_m_axi_rd_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 64,
   parameter int LEN_WIDTH  = 8,
   parameter int DATA_WIDTH = 512
);
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [ADDR_WIDTH-1:0]         m_araddr;
   logic [LEN_WIDTH-1:0]          m_arlen;
   logic                          m_arvalid;
   logic                          m_arready;
   logic [DATA_WIDTH-1:0]         m_rdata;
   logic                          m_rlast;
   logic                          m_rvalid;
   logic                          m_rready;
   logic [DATA_WIDTH-1:0]         rsp_data;
   logic                          rsp_last;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [NUM_REQ-1:0]            rsp_ready;

   modport master (
      input  req_addr, req_len, req_valid, m_arready, m_rdata, m_rlast, m_rvalid, rsp_ready,
      output req_ready, m_araddr, m_arlen, m_arvalid, m_rready, rsp_data, rsp_last, rsp_valid
   );

   modport slave (
      output req_addr, req_len, req_valid, m_arready, m_rdata, m_rlast, m_rvalid, rsp_ready,
      input  req_ready, m_araddr, m_arlen, m_arvalid, m_rready, rsp_data, rsp_last, rsp_valid
   );
endinterface

// File: rtl/weight_loader_m_axi_rd_arbiter.sv
// rtl/weight_loader_m_axi_rd_arbiter.sv - round-robin arbiter sharing one m_axi read channel
module weight_loader_m_axi_rd_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int IDX_WIDTH       = 2,
   parameter int ADDR_WIDTH      = 64,
   parameter int LEN_WIDTH       = 8,
   parameter int DATA_WIDTH      = 512,
   parameter int MAX_OUTSTANDING = 8
) (
   input logic clk,
   input logic reset_n,
   weight_loader_m_axi_rd_arbiter_if.master bus
);
   localparam int PTR_WIDTH = $clog2(MAX_OUTSTANDING) + 1;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                state_q, state_d;
   logic [IDX_WIDTH-1:0]  last_grant_q;
   logic [IDX_WIDTH-1:0]  winner;
   logic [IDX_WIDTH-1:0]  head;
   logic [ADDR_WIDTH-1:0] araddr_q;
   logic [LEN_WIDTH-1:0]  arlen_q;
   logic [IDX_WIDTH-1:0]  route_mem [MAX_OUTSTANDING];
   logic [PTR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
   logic                  found, full, empty, pop, grant;
   logic                  m_rready_c;
   logic [NUM_REQ-1:0]    req_ready_c, rsp_valid_c;
   int                    cand;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_WIDTH-2:0] == rd_ptr_q[PTR_WIDTH-2:0]) &&
                  (wr_ptr_q[PTR_WIDTH-1] != rd_ptr_q[PTR_WIDTH-1]);
   assign head  = route_mem[rd_ptr_q[PTR_WIDTH-2:0]];

   // R beats go straight to whichever requester owns the oldest outstanding burst
   always_comb begin
      m_rready_c  = 1'b0;
      rsp_valid_c = '0;
      if (!empty) begin
         m_rready_c        = bus.rsp_ready[head];
         rsp_valid_c[head] = bus.m_rvalid;
      end
   end

   assign pop = bus.m_rvalid & m_rready_c & bus.m_rlast;

   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(last_grant_q) + k) % NUM_REQ;
         if (!found && bus.req_valid[cand]) begin
            found  = 1'b1;
            winner = IDX_WIDTH'(cand);
         end
      end
   end

   // A final-beat pop in the same cycle frees the slot a grant needs when the FIFO is full
   always_comb begin
      state_d     = state_q;
      grant       = 1'b0;
      req_ready_c = '0;
      case (state_q)
         IDLE: begin
            if (reset_n && found && (!full || pop)) begin
               grant               = 1'b1;
               req_ready_c[winner] = 1'b1;
               state_d             = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.m_arready) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= IDX_WIDTH'(NUM_REQ - 1);
         araddr_q     <= '0;
         arlen_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            last_grant_q <= winner;
            araddr_q     <= bus.req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            arlen_q      <= bus.req_len[int'(winner)*LEN_WIDTH +: LEN_WIDTH];
            wr_ptr_q     <= wr_ptr_q + PTR_WIDTH'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (grant) route_mem[wr_ptr_q[PTR_WIDTH-2:0]] <= winner;
   end

   assign bus.req_ready = req_ready_c;
   assign bus.m_araddr  = araddr_q;
   assign bus.m_arlen   = arlen_q;
   assign bus.m_arvalid = (state_q == ISSUE);
   assign bus.m_rready  = m_rready_c;
   assign bus.rsp_valid = rsp_valid_c;
   assign bus.rsp_data  = bus.m_rdata;
   assign bus.rsp_last  = bus.m_rlast;
endmodule

// File: tb/tb_weight_loader_m_axi_rd_arbiter.sv
// tb/tb_weight_loader_m_axi_rd_arbiter.sv - self-checking bench for the m_axi read arbiter
module tb_weight_loader_m_axi_rd_arbiter;
   localparam int NUM_REQ    = 4;
   localparam int IDX_WIDTH  = 2;
   localparam int ADDR_WIDTH = 64;
   localparam int LEN_WIDTH  = 8;
   localparam int DATA_WIDTH = 512;
   localparam int MAX_OUT    = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   weight_loader_m_axi_rd_arbiter_if #(
      .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .DATA_WIDTH(DATA_WIDTH)
   ) bus ();

   weight_loader_m_axi_rd_arbiter #(
      .NUM_REQ(NUM_REQ), .IDX_WIDTH(IDX_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .LEN_WIDTH(LEN_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic set_req(input int i, input logic [63:0] a, input logic [7:0] l);
      bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
      bus.req_len[i*LEN_WIDTH +: LEN_WIDTH]    = l;
   endtask

   task automatic idle_inputs();
      bus.req_addr  = '0;
      bus.req_len   = '0;
      bus.req_valid = '0;
      bus.m_arready = 1'b0;
      bus.m_rdata   = '0;
      bus.m_rlast   = 1'b0;
      bus.m_rvalid  = 1'b0;
      bus.rsp_ready = '1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   function automatic logic [63:0] rr_addr(input int i);
      return 64'h1000_0000 + 64'(i) * 64'h100;
   endfunction

   typedef struct {
      logic [3:0]  req_valid;
      logic        arready;
      logic [3:0]  exp_ready;
      logic        exp_arvalid;
      logic [63:0] exp_addr;
   } rr_vec_t;

   rr_vec_t rr_tab[10];

   // reference model state
   int          q[$];
   int          last;
   bit          in_issue;
   logic [63:0] m_addr;
   logic [7:0]  m_len;
   logic [3:0]  exp_rv, exp_rr;
   logic        exp_mr, pop;
   int          w, c, n;

   initial begin
      idle_inputs();

      // reset state, with requests and R traffic presented
      bus.req_valid = 4'b1111;
      bus.m_rvalid  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready", 64'(bus.req_ready), 64'h0);
      chk("reset_arvalid", 64'(bus.m_arvalid), 64'h0);
      chk("reset_rready", 64'(bus.m_rready), 64'h0);
      chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'h0);
      chk("reset_araddr", bus.m_araddr, 64'h0);

      // round-robin table
      for (int i = 0; i < 10; i++) begin
         rr_tab[i].req_valid   = 4'b1111;
         rr_tab[i].arready     = 1'b1;
         rr_tab[i].exp_arvalid = (i % 2 == 1);
         rr_tab[i].exp_ready   = (i % 2 == 0) ? 4'(1 << ((i / 2) % 4)) : 4'b0000;
         rr_tab[i].exp_addr    = (i == 0) ? 64'h0 : rr_addr(((i - 1) / 2) % 4);
      end
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, rr_addr(i), 8'd0);
      for (int i = 0; i < 10; i++) begin
         bus.req_valid = rr_tab[i].req_valid;
         bus.m_arready = rr_tab[i].arready;
         @(negedge clk);
         chk($sformatf("rr_ready_c%0d", i + 1), 64'(bus.req_ready), 64'(rr_tab[i].exp_ready));
         chk($sformatf("rr_arvalid_c%0d", i + 1), 64'(bus.m_arvalid), 64'(rr_tab[i].exp_arvalid));
         chk($sformatf("rr_araddr_c%0d", i + 1), bus.m_araddr, rr_tab[i].exp_addr);
         next_cycle();
      end

      // AR backpressure
      do_reset();
      set_req(2, 64'h1000, 8'd15);
      set_req(0, 64'h5000, 8'd2);
      bus.req_valid = 4'b0100;
      @(negedge clk);
      chk("bp_grant", 64'(bus.req_ready), 64'h4);
      next_cycle();
      bus.req_valid = 4'b0001;
      for (int i = 0; i < 6; i++) begin
         bus.m_arready = (i == 5);
         @(negedge clk);
         chk("bp_arvalid", 64'(bus.m_arvalid), 64'h1);
         chk("bp_araddr", bus.m_araddr, 64'h1000);
         chk("bp_arlen", 64'(bus.m_arlen), 64'd15);
         chk("bp_no_grant", 64'(bus.req_ready), 64'h0);
         next_cycle();
      end
      bus.m_arready = 1'b0;
      @(negedge clk);
      chk("bp_back_idle", 64'(bus.m_arvalid), 64'h0);
      chk("bp_next_grant", 64'(bus.req_ready), 64'h1);

      // outstanding limit
      do_reset();
      bus.req_valid = 4'b1111;
      bus.m_arready = 1'b1;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (bus.req_ready != 0) n++;
         next_cycle();
      end
      chk("lim_grants", 64'(n), 64'd8);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("lim_full_no_grant", 64'(bus.req_ready), 64'h0);
         next_cycle();
      end
      bus.m_rvalid = 1'b1;
      bus.m_rlast  = 1'b1;
      @(negedge clk);
      chk("lim_pop_rsp_valid", 64'(bus.rsp_valid), 64'h1);
      chk("lim_pop_rready", 64'(bus.m_rready), 64'h1);
      chk("lim_grant_on_pop", 64'(bus.req_ready), 64'h1);
      next_cycle();
      bus.m_rvalid = 1'b0;
      @(negedge clk);
      chk("lim_issue_after", 64'(bus.m_arvalid), 64'h1);

      // R routing
      do_reset();
      set_req(1, 64'h2000, 8'd3);
      set_req(3, 64'h3000, 8'd1);
      bus.m_arready = 1'b1;
      bus.req_valid = 4'b0010;
      @(negedge clk);
      chk("rt_grant1", 64'(bus.req_ready), 64'h2);
      next_cycle();
      bus.req_valid = 4'b1000;
      @(negedge clk);
      chk("rt_arlen1", 64'(bus.m_arlen), 64'd3);
      next_cycle();
      @(negedge clk);
      chk("rt_grant3", 64'(bus.req_ready), 64'h8);
      next_cycle();
      bus.req_valid = 4'b0000;
      for (int b = 0; b < 6; b++) begin
         bus.m_rvalid = 1'b1;
         bus.m_rdata  = DATA_WIDTH'(b + 160);
         bus.m_rlast  = (b == 3 || b == 5);
         if (b == 4) begin
            bus.rsp_ready = 4'b0111;
            @(negedge clk);
            chk("rt_hold_rready", 64'(bus.m_rready), 64'h0);
            chk("rt_hold_rsp_valid", 64'(bus.rsp_valid), 64'h8);
            next_cycle();
            bus.rsp_ready = 4'b1111;
         end
         @(negedge clk);
         chk($sformatf("rt_rsp_valid_b%0d", b), 64'(bus.rsp_valid), (b < 4) ? 64'h2 : 64'h8);
         chk($sformatf("rt_rready_b%0d", b), 64'(bus.m_rready), 64'h1);
         chk($sformatf("rt_data_b%0d", b), bus.rsp_data[63:0], 64'(b + 160));
         chk($sformatf("rt_last_b%0d", b), 64'(bus.rsp_last), 64'(b == 3 || b == 5));
         next_cycle();
      end
      bus.m_rlast = 1'b0;
      @(negedge clk);
      chk("empty_rready", 64'(bus.m_rready), 64'h0);
      chk("empty_rsp_valid", 64'(bus.rsp_valid), 64'h0);

      // simultaneous push/pop with one outstanding
      next_cycle();
      bus.m_rvalid = 1'b0;
      set_req(0, 64'h4000, 8'd0);
      set_req(2, 64'h6000, 8'd0);
      bus.req_valid = 4'b0001;
      @(negedge clk);
      chk("pp_grant0", 64'(bus.req_ready), 64'h1);
      next_cycle();
      bus.req_valid = 4'b0000;
      next_cycle();
      bus.req_valid = 4'b0100;
      bus.m_rvalid  = 1'b1;
      bus.m_rlast   = 1'b1;
      @(negedge clk);
      chk("pp_grant2", 64'(bus.req_ready), 64'h4);
      chk("pp_pop0", 64'(bus.rsp_valid), 64'h1);
      next_cycle();
      bus.req_valid = 4'b0000;
      @(negedge clk);
      chk("pp_head2", 64'(bus.rsp_valid), 64'h4);
      next_cycle();
      @(negedge clk);
      chk("pp_empty_after", 64'(bus.m_rready), 64'h0);

      // reset mid-burst
      do_reset();
      bus.req_valid = 4'b0111;
      bus.m_arready = 1'b1;
      repeat (5) next_cycle();
      bus.req_valid = 4'b1111;
      bus.m_arready = 1'b0;
      bus.m_rvalid  = 1'b1;
      @(negedge clk);
      chk("mid_arvalid_pre", 64'(bus.m_arvalid), 64'h1);
      chk("mid_rsp_valid_pre", 64'(bus.rsp_valid), 64'h1);
      chk("mid_rready_pre", 64'(bus.m_rready), 64'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_arvalid_async", 64'(bus.m_arvalid), 64'h0);
      chk("mid_rready_async", 64'(bus.m_rready), 64'h0);
      chk("mid_rsp_valid_async", 64'(bus.rsp_valid), 64'h0);
      chk("mid_req_ready_async", 64'(bus.req_ready), 64'h0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      bus.m_rvalid  = 1'b0;
      bus.m_arready = 1'b1;
      @(negedge clk);
      chk("mid_first_grant", 64'(bus.req_ready), 64'h1);

      // randomized run against a queue-based reference model
      do_reset();
      q.delete();
      last     = NUM_REQ - 1;
      in_issue = 0;
      m_addr   = '0;
      m_len    = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
               set_req(i, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
               bus.req_valid[i] = 1'b1;
            end
         end
         bus.m_arready = ($urandom_range(0, 2) != 0);
         bus.m_rvalid  = 1'($urandom_range(0, 1));
         bus.m_rlast   = ($urandom_range(0, 2) == 0);
         bus.rsp_ready = 4'($urandom);
         bus.m_rdata   = DATA_WIDTH'({$urandom, $urandom});
         @(negedge clk);
         exp_mr = 1'b0;
         exp_rv = '0;
         if (q.size() > 0) begin
            exp_mr        = bus.rsp_ready[q[0]];
            exp_rv[q[0]]  = bus.m_rvalid;
         end
         pop = bus.m_rvalid && exp_mr && bus.m_rlast;
         w = -1;
         if (!in_issue && (q.size() - int'(pop)) < MAX_OUT) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               c = (last + k) % NUM_REQ;
               if (w < 0 && bus.req_valid[c]) w = c;
            end
         end
         exp_rr = (w >= 0) ? 4'(1 << w) : 4'b0000;
         chk("rnd_rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
         chk("rnd_rready", 64'(bus.m_rready), 64'(exp_mr));
         chk("rnd_req_ready", 64'(bus.req_ready), 64'(exp_rr));
         chk("rnd_arvalid", 64'(bus.m_arvalid), 64'(in_issue));
         chk("rnd_rsp_data", bus.rsp_data[63:0], bus.m_rdata[63:0]);
         if (in_issue) begin
            chk("rnd_araddr", bus.m_araddr, m_addr);
            chk("rnd_arlen", 64'(bus.m_arlen), 64'(m_len));
         end
         if (pop) void'(q.pop_front());
         if (w >= 0) begin
            q.push_back(w);
            last     = w;
            in_issue = 1;
            m_addr   = bus.req_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
            m_len    = bus.req_len[w*LEN_WIDTH +: LEN_WIDTH];
         end else if (in_issue && bus.m_arready) begin
            in_issue = 0;
         end
         next_cycle();
         if (w >= 0) bus.req_valid[w] = 1'b0;
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
